// File: rtl/adder32_seq.sv
// adder32_seq: multi-cycle 32-bit add/subtract sequencer.
//
// One 8-bit carry-lookahead slice (Adder08) is shared across four byte
// lanes. The carry out of each byte is registered and fed back as the
// carry into the next byte, so one 32-bit operation takes four BUSY cycles.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   op_sub               0 = in1 + in2, 1 = in1 - in2 (sampled at accept)
//   in1, in2             32-bit operands (sampled at accept)
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   out                  32-bit result
//   cout                 carry out of bit 31 (not-borrow for subtract)
//   ovf                  two's-complement signed overflow
//   zero                 result equals zero

// Adder04: 4-bit carry-lookahead nibble. Produces the sum plus group
// generate/propagate so the enclosing slice can look ahead across nibbles.
//   a, b  nibble operands     cin  carry in
//   sum   nibble sum          gg, gp  group generate / propagate
module Adder04 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
  end
endmodule

// Adder08: 8-bit carry-lookahead slice built from two Adder04 nibbles with
// a second lookahead level for the carry into the high nibble and out.
//   cin        carry in
//   in1, in2   byte operands
//   out        byte sum
//   cout       carry out of bit 7
module Adder08 (
  input  logic       cin,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  output logic [7:0] out,
  output logic       cout
);
  logic gg_lo, gp_lo, gg_hi, gp_hi;
  logic c4;

  always_comb begin
    c4   = gg_lo | (gp_lo & cin);
    cout = gg_hi | (gp_hi & gg_lo) | (gp_hi & gp_lo & cin);
  end

  Adder04 u_lo (
    .a   (in1[3:0]),
    .b   (in2[3:0]),
    .cin (cin),
    .sum (out[3:0]),
    .gg  (gg_lo),
    .gp  (gp_lo)
  );

  Adder04 u_hi (
    .a   (in1[7:4]),
    .b   (in2[7:4]),
    .cin (c4),
    .sum (out[7:4]),
    .gg  (gg_hi),
    .gp  (gp_hi)
  );
endmodule

module adder32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        cout,
  output logic        ovf,
  output logic        zero
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic [7:0]  slice_a, slice_b, slice_sum;
  logic        slice_cout;

  // Byte-lane select feeding the shared slice.
  always_comb begin
    slice_a = a_q[7:0];
    slice_b = b_q[7:0];
    case (idx_q)
      2'd0: begin slice_a = a_q[7:0];   slice_b = b_q[7:0];   end
      2'd1: begin slice_a = a_q[15:8];  slice_b = b_q[15:8];  end
      2'd2: begin slice_a = a_q[23:16]; slice_b = b_q[23:16]; end
      default: begin slice_a = a_q[31:24]; slice_b = b_q[31:24]; end
    endcase
  end

  Adder08 u_adder (
    .cin  (carry_q),
    .in1  (slice_a),
    .in2  (slice_b),
    .out  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = in1;
          b_d     = op_sub ? ~in2 : in2;
          carry_d = op_sub;
          idx_d   = '0;
          res_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (idx_q)
          2'd0:    res_d[7:0]   = slice_sum;
          2'd1:    res_d[15:8]  = slice_sum;
          2'd2:    res_d[23:16] = slice_sum;
          default: res_d[31:24] = slice_sum;
        endcase
        carry_d = slice_cout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          cout_d  = slice_cout;
          // Flags use the byte being written this cycle, not the stale res_q.
          ovf_d   = (a_q[31] == b_q[31]) && (slice_sum[7] != a_q[31]);
          zero_d  = (res_q[23:0] == 24'd0) && (slice_sum == 8'd0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out       = res_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end
endmodule
